// File: rtl/i2s_sample_tx.sv
// I2S (Philips) mono sample transmitter: one-entry valid/ready holding
// buffer in front of a BCLK/LRCLK/SDATA serializer.
//
// Ports:
//   clk_i, rst_ni  : clock, synchronous active-low reset
//   enable_i       : run/stop for the serializer
//   sample_i       : signed PCM sample
//   valid_i        : sample_i is valid
//   ready_o        : holding buffer is empty
//   bclk_o         : I2S bit clock
//   lrclk_o        : word select (0 left, 1 right)
//   sdata_o        : serial data, MSB first, one BCLK after LRCLK edge
//   underrun_o     : pulse, frame started with an empty buffer
//   busy_o         : serializer is mid-frame
module i2s_sample_tx #(
  parameter int SAMPLE_W = 16,
  parameter int BCLK_DIV = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                enable_i,
  input  logic [SAMPLE_W-1:0] sample_i,
  input  logic                valid_i,
  output logic                ready_o,
  output logic                bclk_o,
  output logic                lrclk_o,
  output logic                sdata_o,
  output logic                underrun_o,
  output logic                busy_o
);

  localparam int KW = $clog2(2 * SAMPLE_W);
  localparam int DW = $clog2(BCLK_DIV);

  localparam logic [KW-1:0] K_LAST = KW'(2 * SAMPLE_W - 1);
  localparam logic [KW-1:0] K_HALF = KW'(SAMPLE_W);
  localparam logic [DW-1:0] D_TC   = DW'(BCLK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_STOP
  } state_e;

  state_e              state_q, state_d;
  logic [DW-1:0]       div_q, div_d;
  logic [KW-1:0]       k_q, k_d;
  logic                bclk_q, bclk_d;
  logic                lrclk_q, lrclk_d;
  logic                sdata_q, sdata_d;
  logic                under_q, under_d;
  logic                ready_q, ready_d;
  logic                full_q, full_d;
  logic [SAMPLE_W-1:0] buf_q, buf_d;
  logic [SAMPLE_W-1:0] shreg_q, shreg_d;

  logic active;
  logic tc;
  logic fall;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    k_d     = k_q;
    bclk_d  = bclk_q;
    lrclk_d = lrclk_q;
    sdata_d = sdata_q;
    under_d = 1'b0;
    full_d  = full_q;
    buf_d   = buf_q;
    shreg_d = shreg_q;

    active = (state_q != S_IDLE);
    tc     = (div_q == D_TC);
    fall   = active & tc & bclk_q;

    unique case (state_q)
      S_IDLE: if (enable_i)  state_d = S_RUN;
      S_RUN:  if (!enable_i) state_d = S_STOP;
      S_STOP: if (enable_i)  state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase

    if (active) begin
      div_d = tc ? '0 : div_q + 1'b1;
      if (tc) bclk_d = ~bclk_q;
    end

    if (fall) begin
      if (state_q == S_STOP && !enable_i && k_q == '0) begin
        // Frame boundary while stopping: park the outputs and
        // leave the buffer untouched for the next run.
        state_d = S_IDLE;
        k_d     = '0;
        lrclk_d = 1'b0;
        sdata_d = 1'b0;
        shreg_d = '0;
      end else begin
        lrclk_d = (k_q >= K_HALF);
        // The register rotates left once per period after the
        // load; 2W-1 rotations leave the LSB at the top, so the
        // k=0 period carries the previous right-slot LSB.
        sdata_d = shreg_q[SAMPLE_W-1];
        k_d     = (k_q == K_LAST) ? '0 : k_q + 1'b1;
        if (k_q == '0) begin
          shreg_d = full_q ? buf_q : '0;
          under_d = ~full_q;
          full_d  = 1'b0;
        end else begin
          shreg_d = {shreg_q[SAMPLE_W-2:0], shreg_q[SAMPLE_W-1]};
        end
      end
    end

    // A transfer on a load edge lands in the freshly drained buffer.
    if (valid_i && ready_q) begin
      buf_d  = sample_i;
      full_d = 1'b1;
    end

    ready_d = ~full_d;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      k_q     <= '0;
      bclk_q  <= 1'b0;
      lrclk_q <= 1'b0;
      sdata_q <= 1'b0;
      under_q <= 1'b0;
      ready_q <= 1'b0;
      full_q  <= 1'b0;
      buf_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      k_q     <= k_d;
      bclk_q  <= bclk_d;
      lrclk_q <= lrclk_d;
      sdata_q <= sdata_d;
      under_q <= under_d;
      ready_q <= ready_d;
      full_q  <= full_d;
      buf_q   <= buf_d;
      shreg_q <= shreg_d;
    end
  end

  assign ready_o    = ready_q;
  assign bclk_o     = bclk_q;
  assign lrclk_o    = lrclk_q;
  assign sdata_o    = sdata_q;
  assign underrun_o = under_q;
  assign busy_o     = (state_q != S_IDLE);

endmodule

// File: tb/tb_i2s_sample_tx.sv
// Directed testbench for i2s_sample_tx at default parameters
// (16-bit slots, 8-clk BCLK, 256-clk frames).
module tb_i2s_sample_tx;

  logic        clk;
  logic        rst_ni;
  logic        enable_i;
  logic [15:0] sample_i;
  logic        valid_i;
  logic        ready_o;
  logic        bclk_o;
  logic        lrclk_o;
  logic        sdata_o;
  logic        underrun_o;
  logic        busy_o;

  i2s_sample_tx dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .enable_i   (enable_i),
    .sample_i   (sample_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .bclk_o     (bclk_o),
    .lrclk_o    (lrclk_o),
    .sdata_o    (sdata_o),
    .underrun_o (underrun_o),
    .busy_o     (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nchk;
  int nerr;
  int cyc;
  int urun;
  int rdy;
  int nx;
  int c0;
  logic        stream_on;
  int          strm_i;
  logic [15:0] strm [3];
  logic [31:0] bits;
  logic [31:0] lr;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic fire;
    fire = valid_i && ready_o;
    @(posedge clk);
    #1;
    cyc++;
    if (underrun_o) urun++;
    if (ready_o) rdy++;
    if (fire) begin
      nx++;
      if (stream_on && strm_i < 2) begin
        strm_i++;
        sample_i = strm[strm_i];
      end else begin
        valid_i   = 1'b0;
        stream_on = 1'b0;
      end
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push(input logic [15:0] v);
    sample_i = v;
    valid_i  = 1'b1;
    tick();
  endtask

  task automatic wait_fall();
    logic prev;
    bit   hit;
    hit  = 1'b0;
    prev = bclk_o;
    for (int i = 0; i < 64 && !hit; i++) begin
      tick();
      if (prev && !bclk_o) hit = 1'b1;
      prev = bclk_o;
    end
    if (!hit) chk("bclk_fall_timeout", 0, 1);
  endtask

  task automatic wait_rise();
    logic prev;
    bit   hit;
    hit  = 1'b0;
    prev = bclk_o;
    for (int i = 0; i < 64 && !hit; i++) begin
      tick();
      if (!prev && bclk_o) hit = 1'b1;
      prev = bclk_o;
    end
    if (!hit) chk("bclk_rise_timeout", 0, 1);
  endtask

  task automatic wait_k0();
    logic prev;
    bit   hit;
    hit  = 1'b0;
    prev = lrclk_o;
    for (int i = 0; i < 300 && !hit; i++) begin
      tick();
      if (prev && !lrclk_o) hit = 1'b1;
      prev = lrclk_o;
    end
    if (!hit) chk("frame_start_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 300 && !hit; i++) begin
      tick();
      if (!busy_o) hit = 1'b1;
    end
    if (!hit) chk("idle_timeout", 0, 1);
  endtask

  // Captures one frame starting just after its k=0 falling edge:
  // bits[31-p] is sdata at the rising edge of period p.
  task automatic grab(output logic [31:0] b, output logic [31:0] l);
    b = '0;
    l = '0;
    for (int p = 0; p < 32; p++) begin
      wait_rise();
      b[31-p] = sdata_o;
      l[p]    = lrclk_o;
      wait_fall();
    end
  endtask

  function automatic logic [31:0] fr(input logic lsb,
                                     input logic [15:0] s);
    return {lsb, s, s[15:1]};
  endfunction

  initial begin
    nchk = 0; nerr = 0; cyc = 0; urun = 0; rdy = 0; nx = 0;
    stream_on = 1'b0; strm_i = 0;
    strm[0] = 16'h0001; strm[1] = 16'h0002; strm[2] = 16'h0003;
    rst_ni = 1'b0; enable_i = 1'b0; valid_i = 1'b0; sample_i = '0;

    // reset
    ticks(5);
    chk("reset_outs", {bclk_o, lrclk_o, sdata_o, underrun_o,
                       busy_o, ready_o}, 6'b0);
    rst_ni = 1'b1;
    tick();
    chk("ready_after_rst", ready_o, 1'b1);
    ticks(3);
    chk("idle_static", {bclk_o, busy_o}, 2'b0);

    // basic frame
    push(16'hA5F0);
    chk("ready_low_full", ready_o, 1'b0);
    urun = 0;
    enable_i = 1'b1;
    wait_fall();
    c0 = cyc;
    chk("busy_run", busy_o, 1'b1);
    chk("no_urun_first", urun, 0);
    tick();
    chk("ready_after_load", ready_o, 1'b1);
    grab(bits, lr);
    chk("basic_data", bits, fr(1'b0, 16'hA5F0));
    chk("basic_lrclk", lr, 32'hFFFF0000);
    chk("frame_len", cyc - c0, 256);
    chk("basic_urun", urun, 1);

    // underrun
    urun = 0;
    c0 = cyc;
    grab(bits, lr);
    chk("urun_data", bits, 32'h0);
    chk("urun_count", urun, 1);
    chk("urun_period", cyc - c0, 256);
    urun = 0;
    ticks(50);
    push(16'h8001);
    wait_k0();
    chk("no_urun_8001", urun, 0);
    grab(bits, lr);
    chk("data_8001", bits, fr(1'b0, 16'h8001));
    chk("urun_after_8001", urun, 1);

    // backpressure stream
    nx = 0;
    strm_i = 0;
    stream_on = 1'b1;
    sample_i = strm[0];
    valid_i = 1'b1;
    wait_k0();
    rdy = 0;
    grab(bits, lr);
    chk("bp_data1", bits, fr(1'b0, 16'h0001));
    chk("bp_ready1", rdy, 1);
    rdy = 0;
    grab(bits, lr);
    chk("bp_data2", bits, fr(1'b1, 16'h0002));
    chk("bp_ready2", rdy, 1);
    grab(bits, lr);
    chk("bp_data3", bits, fr(1'b0, 16'h0003));
    chk("bp_xfers", nx, 3);

    // stop at k=5 with a buffered sample
    c0 = cyc;
    for (int i = 0; i < 5; i++) wait_fall();
    enable_i = 1'b0;
    push(16'h1234);
    wait_idle();
    chk("stop_len", cyc - c0, 256);
    chk("stop_outs", {bclk_o, lrclk_o, sdata_o, busy_o}, 4'b0);
    ticks(20);
    chk("stop_hold", {bclk_o, busy_o, ready_o}, 3'b0);
    urun = 0;
    enable_i = 1'b1;
    wait_fall();
    chk("reen_no_urun", urun, 0);
    grab(bits, lr);
    chk("reen_data", bits, fr(1'b0, 16'h1234));
    chk("reen_lrclk", lr, 32'hFFFF0000);

    // mid-frame reset
    push(16'h5555);
    for (int i = 0; i < 10; i++) wait_fall();
    rst_ni = 1'b0;
    enable_i = 1'b0;
    tick();
    chk("midrst_outs", {bclk_o, lrclk_o, sdata_o, underrun_o,
                        busy_o, ready_o}, 6'b0);
    ticks(2);
    rst_ni = 1'b1;
    urun = 0;
    tick();
    chk("midrst_empty", ready_o, 1'b1);
    ticks(20);
    chk("midrst_no_urun", urun, 0);
    chk("midrst_idle", {busy_o, bclk_o}, 2'b0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
